minc_run_ctrl: RTL and testbench
================================

// Module: minc_run_ctrl
// PURPOSE
//  Run-control sequencer for the minc stack core. Owns program-memory loading, core reset and
//  per-cycle core enable. Supports RUN, single STEP, HALT and LOAD of 10-bit instruction words.
//  Sits between a host/debug command port and the core (core PC fed back for breakpoints).
// PARAMETERS
//  ADDR_W      8    program address / PC width (program depth = 2**ADDR_W)
//  INSN_W      10   instruction word width
//  CNT_W       16   executed-cycle counter width
//  MAX_CYCLES  0    RUN auto-halt limit; 0 = unlimited
// PORTS
//  CLK         in   1       clock, all state on rising edge
//  nRESET      in   1       asynchronous, active-low reset
//  cmd_valid   in   1       command strobe
//  cmd_ready   out  1       command accepted when cmd_valid & cmd_ready
//  cmd_op      in   2       00 RUN, 01 STEP, 10 HALT, 11 LOAD
//  ld_valid    in   1       load word strobe
//  ld_ready    out  1       high only in LOAD
//  ld_data     in   INSN_W  instruction word to store
//  ld_last     in   1       marks final word of a load
//  pc          in   ADDR_W  core program counter
//  bp_addr     in   ADDR_W  breakpoint address (MINC_BREAKPOINT_EN only)
//  core_en     out  1       core executes one instruction on each edge where high
//  core_rst_n  out  1       active-low reset to core (PC/SP to 0)
//  prog_we     out  1       program-memory write strobe (1-cycle pulse)
//  prog_addr   out  ADDR_W  program-memory write address
//  prog_wdata  out  INSN_W  program-memory write data
//  halted      out  1       high in HALT
//  cycle_cnt   out  CNT_W   instructions executed since last LOAD/reset, saturates at all-ones
// BEHAVIOUR
//  Reset: state IDLE; core_en=0, core_rst_n=0, prog_we=0, prog_addr=0, prog_wdata=0,
//   halted=0, cycle_cnt=0, ld_ready=0, cmd_ready=1. Reset mid-LOAD abandons the load.
//  States IDLE, LOAD, RUN, STEP, HALT. cmd_ready=1 in IDLE/RUN/HALT, 0 in LOAD/STEP.
//  Command accepted at edge N -> new state from N; core_en first high in cycle after N.
//  IDLE: core_rst_n=0. RUN->RUN, STEP->STEP, LOAD->LOAD, HALT accepted as no-op.
//  LOAD: core_rst_n=0, ld_ready=1; write address counter starts at 0, cycle_cnt cleared.
//   Each ld handshake -> next cycle prog_we=1 with prog_addr/prog_wdata registered; counter +1.
//   Handshake with ld_last=1, or on address 2**ADDR_W-1 -> IDLE after that write.
//  RUN: core_rst_n=1; core_en=1 every cycle; cycle_cnt +1 per enabled cycle (saturating).
//   HALT cmd -> HALT, core_en=0 from next cycle. STEP/RUN cmd in RUN: accepted, no effect.
//   LOAD cmd in RUN -> LOAD (core reset asserted immediately).
//   MAX_CYCLES!=0 and cycle_cnt reaches MAX_CYCLES -> HALT; no further enable.
//  STEP: core_en=1 for exactly one cycle, then HALT.
//  HALT: core_rst_n=1 (core state retained), core_en=0, halted=1. RUN/STEP/LOAD as from IDLE.
//  core_en = registered run flag AND NOT bp_hit (bp_hit combinational, only with macro).
// CONFIGURATION
//  MINC_BREAKPOINT_EN defined: in RUN, bp_hit = (pc == bp_addr) forces core_en=0 that cycle
//   and next state HALT; the instruction at bp_addr is not executed. bp_hit masked in the
//   first enabled cycle after a RUN/STEP accept, so resume from a breakpoint makes progress.
//   STEP never breaks.
//  Not defined: bp_addr port absent, bp_hit tied 0, no breakpoint logic.
// STRUCTURE
//  minc_pkg: state encoding (IDLE..HALT), cmd_op codes, default ADDR_W/INSN_W.
//  Sub-module minc_prog_loader: ld handshake, address counter, registered write port,
//   done flag on ld_last/wrap. Top holds FSM, cycle counter, breakpoint compare.
// TESTING
//  Reset, LOAD, words 0x005,0x003,0x100 (ld_last on 3rd) -> prog_we pulses at addr 0,1,2; IDLE.
//  LOAD 256 words, no ld_last -> 256 writes, addr wraps 255->IDLE, ld_ready drops.
//  RUN then HALT 4 cycles later -> core_en high 4 cycles, cycle_cnt=4, halted=1.
//  From HALT, STEP x3 -> exactly 3 single-cycle core_en pulses, cycle_cnt=7.
//  MAX_CYCLES=10, RUN -> core_en high 10 cycles, auto HALT; nRESET low mid-RUN -> reset values.
//  MINC_BREAKPOINT_EN, bp_addr=2, RUN -> HALT with pc=2, core_en low; RUN again -> passes 2.

Source files
------------

// File: rtl/minc_pkg.sv
// minc_pkg: shared types and defaults for the minc run-control block.
// FSM state encoding, host command opcodes and default bus widths.
package minc_pkg;

    localparam int MINC_ADDR_W = 8;
    localparam int MINC_INSN_W = 10;
    localparam int MINC_CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_RUN  = 2'b00,
        OP_STEP = 2'b01,
        OP_HALT = 2'b10,
        OP_LOAD = 2'b11
    } cmd_op_t;

    // Core is out of reset whenever it has been started since the last load.
    function automatic logic core_released(input state_t s);
        return (s == ST_RUN) || (s == ST_STEP) || (s == ST_HALT);
    endfunction

endpackage

// File: rtl/minc_run_ctrl_if.sv
// minc_run_ctrl_if: host/debug command port and program-load stream.
// master = host side, slave = run controller.
interface minc_run_ctrl_if
    import minc_pkg::*;
#(
    parameter int INSN_W = MINC_INSN_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic              ld_valid;
    logic              ld_ready;
    logic [INSN_W-1:0] ld_data;
    logic              ld_last;

    modport master (
        output cmd_valid, cmd_op, ld_valid, ld_data, ld_last,
        input  cmd_ready, ld_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, ld_valid, ld_data, ld_last,
        output cmd_ready, ld_ready
    );

endinterface

// File: rtl/minc_prog_loader.sv
// minc_prog_loader: program-memory load path.
// Accepts ld words while the controller is in LOAD, registers one write per
// word into the program memory, and flags completion on ld_last or when the
// last address of the memory has been taken.
module minc_prog_loader
    import minc_pkg::*;
#(
    parameter int ADDR_W = MINC_ADDR_W,
    parameter int INSN_W = MINC_INSN_W
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              load_start,
    input  logic              load_active,
    input  logic              ld_valid,
    input  logic [INSN_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              load_done,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [INSN_W-1:0] prog_wdata
);

    logic              ld_fire;
    logic [ADDR_W-1:0] addr_d,       addr_q;
    logic              we_d,         we_q;
    logic [ADDR_W-1:0] wr_addr_d,    wr_addr_q;
    logic [INSN_W-1:0] wr_data_d,    wr_data_q;

    assign ld_ready = load_active;
    assign ld_fire  = ld_valid & load_active;

    // Address counter and next write-port contents.
    always_comb begin
        addr_d    = addr_q;
        we_d      = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (load_start) begin
            addr_d = '0;
        end else if (ld_fire) begin
            addr_d    = addr_q + ADDR_W'(1);
            we_d      = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = ld_data;
        end
        // Taking the top address ends the load even without ld_last.
        load_done = ld_fire & (ld_last | (&addr_q));
    end

    // Write-port registers; address/data hold their last value between writes.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            addr_q    <= addr_d;
            we_q      <= we_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign prog_we    = we_q;
    assign prog_addr  = wr_addr_q;
    assign prog_wdata = wr_data_q;

endmodule

// File: rtl/minc_run_ctrl.sv
// minc_run_ctrl: run-control sequencer for the minc stack core.
// Owns program loading, core reset and per-cycle core enable.
// Optional build macro MINC_BREAKPOINT_EN adds the bp_addr port and a
// PC breakpoint that halts RUN before the instruction at bp_addr executes.
//
//  state | meaning
//  IDLE  | core held in reset, waiting for a command
//  LOAD  | core in reset, accepting program words
//  RUN   | core enabled every cycle
//  STEP  | core enabled for one cycle, then HALT
//  HALT  | core out of reset but stopped, state retained
module minc_run_ctrl
    import minc_pkg::*;
#(
    parameter int ADDR_W     = MINC_ADDR_W,
    parameter int INSN_W     = MINC_INSN_W,
    parameter int CNT_W      = MINC_CNT_W,
    parameter int MAX_CYCLES = 0
) (
    input  logic              CLK,
    input  logic              nRESET,
    minc_run_ctrl_if.slave    host,
    input  logic [ADDR_W-1:0] pc,
`ifdef MINC_BREAKPOINT_EN
    input  logic [ADDR_W-1:0] bp_addr,
`endif
    output logic              core_en,
    output logic              core_rst_n,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [INSN_W-1:0] prog_wdata,
    output logic              halted,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam bit               LIMIT_EN = (MAX_CYCLES != 0);
    localparam logic [CNT_W:0]   MAX_LIM  = (CNT_W+1)'(MAX_CYCLES);

    state_t           state_d,      state_q;
    logic             run_d,        run_q;
    logic             first_d,      first_q;
    logic             cmd_ready_d,  cmd_ready_q;
    logic             ld_ready_d,   ld_ready_q;
    logic             halted_d,     halted_q;
    logic             core_rst_n_d, core_rst_n_q;
    logic [CNT_W-1:0] cycle_cnt_d,  cycle_cnt_q;

    logic             bp_hit;
    logic             core_en_w;
    logic             cmd_fire;
    cmd_op_t          op;
    logic             load_start;
    logic             load_done;
    logic             ld_ready_w;

`ifdef MINC_BREAKPOINT_EN
    // The first enabled cycle after a RUN/STEP accept is exempt so that
    // resuming from a breakpoint executes the instruction it stopped on.
    assign bp_hit = (state_q == ST_RUN) && !first_q && (pc == bp_addr);
`else
    logic unused_bp_inputs;
    assign bp_hit           = 1'b0;
    assign unused_bp_inputs = ^{pc, first_q};
`endif

    assign core_en_w = run_q & ~bp_hit;
    assign cmd_fire  = host.cmd_valid & cmd_ready_q;
    assign op        = cmd_op_t'(host.cmd_op);

    // Next-state, cycle counter and registered output decode.
    always_comb begin
        state_d     = state_q;
        first_d     = 1'b0;
        load_start  = 1'b0;
        cycle_cnt_d = cycle_cnt_q;

        if (core_en_w && !(&cycle_cnt_q)) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (cmd_fire) begin
                    case (op)
                        OP_RUN: begin
                            // A spent cycle budget leaves the core stopped.
                            if (LIMIT_EN && ({1'b0, cycle_cnt_q} >= MAX_LIM)) begin
                                state_d = ST_HALT;
                            end else begin
                                state_d = ST_RUN;
                                first_d = 1'b1;
                            end
                        end
                        OP_STEP: begin
                            state_d = ST_STEP;
                            first_d = 1'b1;
                        end
                        OP_LOAD: begin
                            state_d    = ST_LOAD;
                            load_start = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                if (load_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cmd_fire && (op == OP_LOAD)) begin
                    state_d    = ST_LOAD;
                    load_start = 1'b1;
                end else if (cmd_fire && (op == OP_HALT)) begin
                    state_d = ST_HALT;
                end else if (bp_hit) begin
                    state_d = ST_HALT;
                end else if (LIMIT_EN && core_en_w && ({1'b0, cycle_cnt_d} >= MAX_LIM)) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_start) begin
            cycle_cnt_d = '0;
        end

        run_d        = (state_d == ST_RUN) || (state_d == ST_STEP);
        cmd_ready_d  = (state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_HALT);
        ld_ready_d   = (state_d == ST_LOAD);
        halted_d     = (state_d == ST_HALT);
        core_rst_n_d = core_released(state_d);
    end

    // Run-control FSM state and its registered outputs.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q      <= ST_IDLE;
            run_q        <= 1'b0;
            first_q      <= 1'b0;
            cmd_ready_q  <= 1'b1;
            ld_ready_q   <= 1'b0;
            halted_q     <= 1'b0;
            core_rst_n_q <= 1'b0;
            cycle_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            first_q      <= first_d;
            cmd_ready_q  <= cmd_ready_d;
            ld_ready_q   <= ld_ready_d;
            halted_q     <= halted_d;
            core_rst_n_q <= core_rst_n_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    minc_prog_loader #(
        .ADDR_W (ADDR_W),
        .INSN_W (INSN_W)
    ) u_loader (
        .CLK         (CLK),
        .nRESET      (nRESET),
        .load_start  (load_start),
        .load_active (ld_ready_q),
        .ld_valid    (host.ld_valid),
        .ld_data     (host.ld_data),
        .ld_last     (host.ld_last),
        .ld_ready    (ld_ready_w),
        .load_done   (load_done),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_wdata  (prog_wdata)
    );

    assign host.cmd_ready = cmd_ready_q;
    assign host.ld_ready  = ld_ready_w;
    assign core_en        = core_en_w;
    assign core_rst_n     = core_rst_n_q;
    assign halted         = halted_q;
    assign cycle_cnt      = cycle_cnt_q;

endmodule

// File: tb/tb_minc_run_ctrl.sv
// tb_minc_run_ctrl: self-checking bench for minc_run_ctrl.
// u_dut runs unlimited (MAX_CYCLES=0); u_dut_max has a 10-cycle RUN budget.
// A tiny core model advances pc on each enabled edge; expectations come from
// a running count of executed instructions and a list of loaded words.
module tb_minc_run_ctrl;
    import minc_pkg::*;

    localparam int ADDR_W = 8;
    localparam int INSN_W = 10;
    localparam int CNT_W  = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [INSN_W-1:0] d;
    } wr_t;

    logic CLK    = 1'b0;
    logic nRESET = 1'b1;
    always #5 CLK = ~CLK;

    minc_run_ctrl_if #(.INSN_W(INSN_W)) h  ();
    minc_run_ctrl_if #(.INSN_W(INSN_W)) h2 ();

    logic [ADDR_W-1:0] pc = '0;
    logic [ADDR_W-1:0] bp_addr = 8'd200;
    logic              core_en, core_rst_n, prog_we, halted;
    logic [ADDR_W-1:0] prog_addr;
    logic [INSN_W-1:0] prog_wdata;
    logic [CNT_W-1:0]  cycle_cnt;

    logic [ADDR_W-1:0] pc_2 = '0;
    logic              core_en_2, core_rst_n_2, prog_we_2, halted_2;
    logic [ADDR_W-1:0] prog_addr_2;
    logic [INSN_W-1:0] prog_wdata_2;
    logic [CNT_W-1:0]  cycle_cnt_2;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    int en_cycles = 0;
    int en_pulses = 0;
    int en2_cycles = 0;
    logic en_prev = 1'b0;
    wr_t wr_q[$];

    minc_run_ctrl #(.ADDR_W(ADDR_W), .INSN_W(INSN_W), .CNT_W(CNT_W), .MAX_CYCLES(0)) u_dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .host       (h),
        .pc         (pc),
`ifdef MINC_BREAKPOINT_EN
        .bp_addr    (bp_addr),
`endif
        .core_en    (core_en),
        .core_rst_n (core_rst_n),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .halted     (halted),
        .cycle_cnt  (cycle_cnt)
    );

    minc_run_ctrl #(.ADDR_W(ADDR_W), .INSN_W(INSN_W), .CNT_W(CNT_W), .MAX_CYCLES(10)) u_dut_max (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .host       (h2),
        .pc         (pc_2),
`ifdef MINC_BREAKPOINT_EN
        .bp_addr    (bp_addr),
`endif
        .core_en    (core_en_2),
        .core_rst_n (core_rst_n_2),
        .prog_we    (prog_we_2),
        .prog_addr  (prog_addr_2),
        .prog_wdata (prog_wdata_2),
        .halted     (halted_2),
        .cycle_cnt  (cycle_cnt_2)
    );

    // Core model: PC clears while held in reset, advances per enabled edge.
    always @(posedge CLK) begin
        if (!core_rst_n) pc <= '0;
        else if (core_en) pc <= pc + 1'b1;
    end

    // Mid-cycle observers for enables and program writes.
    always @(negedge CLK) begin
        if (core_en) begin
            en_cycles++;
            if (!en_prev) en_pulses++;
        end
        en_prev = core_en;
        if (prog_we) wr_q.push_back('{prog_addr, prog_wdata});
        if (core_en_2) en2_cycles++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op);
        int n = 0;
        h.cmd_valid = 1'b1;
        h.cmd_op    = op;
        while (!h.cmd_ready && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (h.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_timeout: got %b exp 1 (op %0d)", h.cmd_ready, op);
        end
        tick();
        h.cmd_valid = 1'b0;
    endtask

    task automatic send_cmd2(input logic [1:0] op);
        int n = 0;
        h2.cmd_valid = 1'b1;
        h2.cmd_op    = op;
        while (!h2.cmd_ready && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (h2.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd2_ready_timeout: got %b exp 1", h2.cmd_ready);
        end
        tick();
        h2.cmd_valid = 1'b0;
    endtask

    task automatic ld_word(input logic [INSN_W-1:0] data, input logic last);
        int n = 0;
        repeat ($urandom_range(0, 2)) tick();
        h.ld_valid = 1'b1;
        h.ld_data  = data;
        h.ld_last  = last;
        while (!h.ld_ready && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (h.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL ld_ready_timeout: got %b exp 1", h.ld_ready);
        end
        tick();
        h.ld_valid = 1'b0;
        h.ld_last  = 1'b0;
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        h.cmd_valid = 1'b1;
        h.ld_valid  = 1'b1;
        repeat (3) tick();
        checks += 9;
        if (core_en !== 1'b0)    begin errors++; $display("FAIL rst_core_en: got %b exp 0", core_en); end
        if (core_rst_n !== 1'b0) begin errors++; $display("FAIL rst_core_rst_n: got %b exp 0", core_rst_n); end
        if (prog_we !== 1'b0)    begin errors++; $display("FAIL rst_prog_we: got %b exp 0", prog_we); end
        if (prog_addr !== '0)    begin errors++; $display("FAIL rst_prog_addr: got %0h exp 0", prog_addr); end
        if (prog_wdata !== '0)   begin errors++; $display("FAIL rst_prog_wdata: got %0h exp 0", prog_wdata); end
        if (halted !== 1'b0)     begin errors++; $display("FAIL rst_halted: got %b exp 0", halted); end
        if (cycle_cnt !== '0)    begin errors++; $display("FAIL rst_cycle_cnt: got %0d exp 0", cycle_cnt); end
        if (h.ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ld_ready: got %b exp 0", h.ld_ready); end
        if (h.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b exp 1", h.cmd_ready); end
        h.cmd_valid = 1'b0;
        h.ld_valid  = 1'b0;
        tick();
        nRESET = 1'b1;
        tick();
    endtask

    task automatic test_load_short();
        logic [INSN_W-1:0] words[3];
        int base;
        words[0] = 10'h005;
        words[1] = 10'h003;
        words[2] = 10'h100;
        base = wr_q.size();
        send_cmd(OP_LOAD);
        checks += 3;
        if (h.ld_ready !== 1'b1)  begin errors++; $display("FAIL load_ld_ready: got %b exp 1", h.ld_ready); end
        if (h.cmd_ready !== 1'b0) begin errors++; $display("FAIL load_cmd_ready: got %b exp 0", h.cmd_ready); end
        if (core_rst_n !== 1'b0)  begin errors++; $display("FAIL load_core_rst_n: got %b exp 0", core_rst_n); end
        for (int i = 0; i < 3; i++) ld_word(words[i], i == 2);
        checks += 5;
        if (prog_we !== 1'b1)       begin errors++; $display("FAIL short_last_we: got %b exp 1", prog_we); end
        if (prog_addr !== 8'd2)     begin errors++; $display("FAIL short_last_addr: got %0d exp 2", prog_addr); end
        if (prog_wdata !== 10'h100) begin errors++; $display("FAIL short_last_data: got %0h exp 100", prog_wdata); end
        if (h.ld_ready !== 1'b0)    begin errors++; $display("FAIL short_ld_ready_drop: got %b exp 0", h.ld_ready); end
        if (h.cmd_ready !== 1'b1)   begin errors++; $display("FAIL short_idle_cmd_ready: got %b exp 1", h.cmd_ready); end
        tick();
        checks += 2;
        if (prog_we !== 1'b0) begin errors++; $display("FAIL short_we_pulse: got %b exp 0", prog_we); end
        if (wr_q.size() - base != 3) begin
            errors++; $display("FAIL short_write_count: got %0d exp 3", wr_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_q[base+i].a !== ADDR_W'(i) || wr_q[base+i].d !== words[i]) begin
                    errors++;
                    $display("FAIL short_write_%0d: got %0d/%0h exp %0d/%0h", i, wr_q[base+i].a, wr_q[base+i].d, i, words[i]);
                end
            end
        end
        exp_cnt = 0;
    endtask

    task automatic test_load_full();
        logic [INSN_W-1:0] exp_mem[256];
        int base;
        base = wr_q.size();
        send_cmd(OP_LOAD);
        checks++;
        if (cycle_cnt !== '0) begin errors++; $display("FAIL full_cnt_clear: got %0d exp 0", cycle_cnt); end
        for (int i = 0; i < 256; i++) begin
            exp_mem[i] = INSN_W'($urandom_range(0, 1023));
            ld_word(exp_mem[i], 1'b0);
        end
        checks += 2;
        if (h.ld_ready !== 1'b0)  begin errors++; $display("FAIL full_ld_ready_drop: got %b exp 0", h.ld_ready); end
        if (h.cmd_ready !== 1'b1) begin errors++; $display("FAIL full_idle_cmd_ready: got %b exp 1", h.cmd_ready); end
        repeat (2) tick();
        checks++;
        if (wr_q.size() - base != 256) begin
            errors++; $display("FAIL full_write_count: got %0d exp 256", wr_q.size() - base);
        end else begin
            for (int i = 0; i < 256; i++) begin
                checks++;
                if (wr_q[base+i].a !== ADDR_W'(i) || wr_q[base+i].d !== exp_mem[i]) begin
                    errors++;
                    $display("FAIL full_write_%0d: got %0d/%0h exp %0d/%0h", i, wr_q[base+i].a, wr_q[base+i].d, i, exp_mem[i]);
                end
            end
        end
        exp_cnt = 0;
    endtask

    task automatic test_run_halt(input int len, input bit inject);
        int b_cyc, b_pul, mid;
        b_cyc = en_cycles;
        b_pul = en_pulses;
        mid   = (len > 2) ? int'($urandom_range(1, len - 2)) : -1;
        send_cmd(OP_RUN);
        checks += 3;
        if (core_en !== 1'b1)    begin errors++; $display("FAIL run_core_en: got %b exp 1", core_en); end
        if (core_rst_n !== 1'b1) begin errors++; $display("FAIL run_core_rst_n: got %b exp 1", core_rst_n); end
        if (halted !== 1'b0)     begin errors++; $display("FAIL run_halted: got %b exp 0", halted); end
        for (int j = 1; j < len; j++) begin
            if (inject && j == mid) send_cmd($urandom_range(0, 1) != 0 ? OP_STEP : OP_RUN);
            else tick();
        end
        send_cmd(OP_HALT);
        checks += 3;
        if (core_en !== 1'b0)    begin errors++; $display("FAIL halt_core_en: got %b exp 0", core_en); end
        if (halted !== 1'b1)     begin errors++; $display("FAIL halt_halted: got %b exp 1", halted); end
        if (core_rst_n !== 1'b1) begin errors++; $display("FAIL halt_core_rst_n: got %b exp 1", core_rst_n); end
        repeat (2) tick();
        exp_cnt += len;
        checks += 3;
        if (en_cycles - b_cyc != len) begin errors++; $display("FAIL run_en_cycles: got %0d exp %0d", en_cycles - b_cyc, len); end
        if (en_pulses - b_pul != 1)   begin errors++; $display("FAIL run_en_pulses: got %0d exp 1", en_pulses - b_pul); end
        if (cycle_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL run_cycle_cnt: got %0d exp %0d", cycle_cnt, exp_cnt); end
    endtask

    task automatic test_step(input int k);
        int b_cyc, b_pul;
        b_cyc = en_cycles;
        b_pul = en_pulses;
        for (int i = 0; i < k; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_cmd(OP_STEP);
            checks += 2;
            if (core_en !== 1'b1)     begin errors++; $display("FAIL step_core_en: got %b exp 1", core_en); end
            if (h.cmd_ready !== 1'b0) begin errors++; $display("FAIL step_cmd_ready: got %b exp 0", h.cmd_ready); end
        end
        repeat (2) tick();
        exp_cnt += k;
        checks += 4;
        if (en_cycles - b_cyc != k) begin errors++; $display("FAIL step_en_cycles: got %0d exp %0d", en_cycles - b_cyc, k); end
        if (en_pulses - b_pul != k) begin errors++; $display("FAIL step_en_pulses: got %0d exp %0d", en_pulses - b_pul, k); end
        if (cycle_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL step_cycle_cnt: got %0d exp %0d", cycle_cnt, exp_cnt); end
        if (halted !== 1'b1) begin errors++; $display("FAIL step_halted: got %b exp 1", halted); end
    endtask

    task automatic test_load_from_run();
        send_cmd(OP_RUN);
        repeat (3) tick();
        send_cmd(OP_LOAD);
        checks += 5;
        if (core_rst_n !== 1'b0) begin errors++; $display("FAIL rl_core_rst_n: got %b exp 0", core_rst_n); end
        if (core_en !== 1'b0)    begin errors++; $display("FAIL rl_core_en: got %b exp 0", core_en); end
        if (h.ld_ready !== 1'b1) begin errors++; $display("FAIL rl_ld_ready: got %b exp 1", h.ld_ready); end
        if (cycle_cnt !== '0)    begin errors++; $display("FAIL rl_cycle_cnt: got %0d exp 0", cycle_cnt); end
        if (halted !== 1'b0)     begin errors++; $display("FAIL rl_halted: got %b exp 0", halted); end
        ld_word(INSN_W'($urandom_range(0, 1023)), 1'b1);
        exp_cnt = 0;
        send_cmd(OP_HALT);
        tick();
        checks += 3;
        if (halted !== 1'b0)      begin errors++; $display("FAIL idle_halt_noop_halted: got %b exp 0", halted); end
        if (h.cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_halt_noop_ready: got %b exp 1", h.cmd_ready); end
        if (core_rst_n !== 1'b0)  begin errors++; $display("FAIL idle_halt_noop_rst: got %b exp 0", core_rst_n); end
    endtask

`ifdef MINC_BREAKPOINT_EN
    task automatic test_breakpoint();
        bp_addr = 8'd2;
        send_cmd(OP_RUN);
        repeat (8) tick();
        exp_cnt += 2;
        checks += 4;
        if (pc !== 8'd2)      begin errors++; $display("FAIL bp_pc: got %0d exp 2", pc); end
        if (halted !== 1'b1)  begin errors++; $display("FAIL bp_halted: got %b exp 1", halted); end
        if (core_en !== 1'b0) begin errors++; $display("FAIL bp_core_en: got %b exp 0", core_en); end
        if (cycle_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL bp_cnt: got %0d exp %0d", cycle_cnt, exp_cnt); end
        send_cmd(OP_RUN);
        repeat (2) tick();
        send_cmd(OP_HALT);
        exp_cnt += 3;
        checks += 2;
        if (pc !== 8'd5) begin errors++; $display("FAIL bp_resume_pc: got %0d exp 5", pc); end
        if (cycle_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL bp_resume_cnt: got %0d exp %0d", cycle_cnt, exp_cnt); end
        bp_addr = 8'd5;
        send_cmd(OP_STEP);
        repeat (2) tick();
        exp_cnt += 1;
        checks += 2;
        if (pc !== 8'd6)     begin errors++; $display("FAIL bp_step_pc: got %0d exp 6", pc); end
        if (halted !== 1'b1) begin errors++; $display("FAIL bp_step_halted: got %b exp 1", halted); end
        bp_addr = 8'd200;
    endtask
`endif

    task automatic test_max_cycles();
        int b;
        b = en2_cycles;
        send_cmd2(OP_RUN);
        repeat (25) tick();
        checks += 4;
        if (en2_cycles - b != 10)     begin errors++; $display("FAIL max_en_cycles: got %0d exp 10", en2_cycles - b); end
        if (cycle_cnt_2 !== CNT_W'(10)) begin errors++; $display("FAIL max_cycle_cnt: got %0d exp 10", cycle_cnt_2); end
        if (halted_2 !== 1'b1)        begin errors++; $display("FAIL max_halted: got %b exp 1", halted_2); end
        if (core_en_2 !== 1'b0)       begin errors++; $display("FAIL max_core_en: got %b exp 0", core_en_2); end
        send_cmd2(OP_RUN);
        repeat (5) tick();
        checks += 2;
        if (en2_cycles - b != 10)     begin errors++; $display("FAIL max_rerun_en: got %0d exp 10", en2_cycles - b); end
        if (halted_2 !== 1'b1)        begin errors++; $display("FAIL max_rerun_halted: got %b exp 1", halted_2); end
    endtask

    task automatic test_reset_mid_run();
        send_cmd(OP_RUN);
        repeat (3) tick();
        #2 nRESET = 1'b0;
        #1;
        checks += 8;
        if (core_en !== 1'b0)     begin errors++; $display("FAIL mid_rst_core_en: got %b exp 0", core_en); end
        if (core_rst_n !== 1'b0)  begin errors++; $display("FAIL mid_rst_core_rst_n: got %b exp 0", core_rst_n); end
        if (halted !== 1'b0)      begin errors++; $display("FAIL mid_rst_halted: got %b exp 0", halted); end
        if (cycle_cnt !== '0)     begin errors++; $display("FAIL mid_rst_cycle_cnt: got %0d exp 0", cycle_cnt); end
        if (h.cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_cmd_ready: got %b exp 1", h.cmd_ready); end
        if (h.ld_ready !== 1'b0)  begin errors++; $display("FAIL mid_rst_ld_ready: got %b exp 0", h.ld_ready); end
        if (halted_2 !== 1'b0)    begin errors++; $display("FAIL mid_rst_halted_2: got %b exp 0", halted_2); end
        if (cycle_cnt_2 !== '0)   begin errors++; $display("FAIL mid_rst_cycle_cnt_2: got %0d exp 0", cycle_cnt_2); end
        tick();
        nRESET = 1'b1;
        exp_cnt = 0;
        tick();
    endtask

    initial begin
        h.cmd_valid  = 1'b0;
        h.cmd_op     = 2'b00;
        h.ld_valid   = 1'b0;
        h.ld_data    = '0;
        h.ld_last    = 1'b0;
        h2.cmd_valid = 1'b0;
        h2.cmd_op    = 2'b00;
        h2.ld_valid  = 1'b0;
        h2.ld_data   = '0;
        h2.ld_last   = 1'b0;
        #2;
        test_reset();
        test_load_short();
        test_run_halt(4, 1'b0);
        test_step(3);
        for (int i = 0; i < 4; i++) test_run_halt(int'($urandom_range(1, 12)), 1'b1);
        test_load_full();
        test_run_halt(int'($urandom_range(2, 9)), 1'b0);
        test_load_from_run();
`ifdef MINC_BREAKPOINT_EN
        test_breakpoint();
`endif
        test_max_cycles();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
